// File: rtl/multdiv_ctrl.sv
// Sequencing controller for a shared iterative multiplier and divider.
// It latches the operands, steps the iteration counter and captures the final result behind one ready pulse.
module multdiv_ctrl #(
    parameter int unsigned MULT_LAST = 16,
    parameter int unsigned DIV_LAST  = 32,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [31:0]      data_operandA,
    input  logic [31:0]      data_operandB,
    output logic [31:0]      op_a,
    output logic [31:0]      op_b,
    output logic [CNT_W-1:0] counter,
    input  logic [31:0]      mult_result,
    input  logic             mult_ovf,
    input  logic [31:0]      div_result,
    input  logic             div_exc,
    output logic [31:0]      data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] MULT_LAST_C = CNT_W'(MULT_LAST);
    localparam logic [CNT_W-1:0] DIV_LAST_C  = CNT_W'(DIV_LAST);

    state_t           state_r;
    logic [31:0]      op_a_r;
    logic [31:0]      op_b_r;
    logic [CNT_W-1:0] counter_r;
    logic [31:0]      result_r;
    logic             exception_r;
    logic             rdy_r;
    logic             busy_r;

    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [31:0]      result_nxt_s;
    logic             exception_nxt_s;
    logic             load_s;
    logic             done_s;
    logic             div_by_zero_s;

    // Next-state decode; a start pulse always wins over the running operation, MULT over DIV.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = counter_r;
        result_nxt_s    = result_r;
        exception_nxt_s = exception_r;
        load_s          = 1'b0;
        done_s          = 1'b0;
        div_by_zero_s   = (op_b_r == 32'd0) && (counter_r == CNT_ZERO);
        if (ctrl_MULT) begin
            load_s      = 1'b1;
            cnt_nxt_s   = CNT_ZERO;
            state_nxt_s = ST_MUL;
        end else if (ctrl_DIV) begin
            load_s      = 1'b1;
            cnt_nxt_s   = CNT_ZERO;
            state_nxt_s = ST_DIV;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_nxt_s = CNT_ZERO;
                end
                ST_MUL: begin
                    if (counter_r >= MULT_LAST_C) begin
                        result_nxt_s    = mult_result;
                        exception_nxt_s = mult_ovf;
                        done_s          = 1'b1;
                        cnt_nxt_s       = CNT_ZERO;
                        state_nxt_s     = ST_IDLE;
                    end else begin
                        cnt_nxt_s = counter_r + CNT_ONE;
                    end
                end
                ST_DIV: begin
                    // A zero divisor is reported straight away instead of running the full divide.
                    if (div_by_zero_s) begin
                        result_nxt_s    = 32'd0;
                        exception_nxt_s = 1'b1;
                        done_s          = 1'b1;
                        cnt_nxt_s       = CNT_ZERO;
                        state_nxt_s     = ST_IDLE;
                    end else if (counter_r >= DIV_LAST_C) begin
                        result_nxt_s    = div_result;
                        exception_nxt_s = div_exc;
                        done_s          = 1'b1;
                        cnt_nxt_s       = CNT_ZERO;
                        state_nxt_s     = ST_IDLE;
                    end else begin
                        cnt_nxt_s = counter_r + CNT_ONE;
                    end
                end
                default: begin
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Controller state and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            counter_r   <= CNT_ZERO;
            op_a_r      <= 32'd0;
            op_b_r      <= 32'd0;
            result_r    <= 32'd0;
            exception_r <= 1'b0;
            rdy_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            counter_r   <= cnt_nxt_s;
            result_r    <= result_nxt_s;
            exception_r <= exception_nxt_s;
            rdy_r       <= done_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
            if (load_s) begin
                op_a_r <= data_operandA;
                op_b_r <= data_operandB;
            end else begin
                op_a_r <= op_a_r;
                op_b_r <= op_b_r;
            end
        end
    end

    assign op_a           = op_a_r;
    assign op_b           = op_b_r;
    assign counter        = counter_r;
    assign data_result    = result_r;
    assign data_exception = exception_r;
    assign data_resultRDY = rdy_r;
    assign busy           = busy_r;

endmodule
